// File: rtl/axis_iq_packetizer.sv
// Joins separate real/imag AXI streams into one interleaved I/Q stream framed for an S2MM DMA.
// Optional sticky tlast-mismatch flag enabled by defining IQ_PKT_ERRFLAG_EN.
module axis_iq_packetizer #(
  parameter int unsigned SDATA_WIDTH  = 128,
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned SAMPLES      = SDATA_WIDTH / SAMPLE_WIDTH,
  parameter int unsigned PACKET_BEATS = 256
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     s_axis_real_tvalid,
  output logic                     s_axis_real_tready,
  input  logic [SDATA_WIDTH-1:0]   s_axis_real_tdata,
  input  logic                     s_axis_real_tlast,
  input  logic                     s_axis_imag_tvalid,
  output logic                     s_axis_imag_tready,
  input  logic [SDATA_WIDTH-1:0]   s_axis_imag_tdata,
  input  logic                     s_axis_imag_tlast,
  output logic [SDATA_WIDTH-1:0]   m_axis_s2mm_tdata,
  output logic [SDATA_WIDTH/8-1:0] m_axis_s2mm_tkeep,
  output logic                     m_axis_s2mm_tvalid,
  input  logic                     m_axis_s2mm_tready,
`ifdef IQ_PKT_ERRFLAG_EN
  output logic                     err_tlast_mismatch,
`endif
  output logic                     m_axis_s2mm_tlast
);

  localparam int unsigned Half = SAMPLES / 2;
  localparam int unsigned CntW = (PACKET_BEATS > 1) ? $clog2(PACKET_BEATS) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(PACKET_BEATS - 1);

  typedef enum logic [1:0] {StEmpty, StLo, StHi} state_e;

  state_e                 state_q, state_d;
  logic [SDATA_WIDTH-1:0] real_q, real_d;
  logic [SDATA_WIDTH-1:0] imag_q, imag_d;
  logic                   in_last_q, in_last_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   can_accept;
  logic                   join_pair;
  logic                   out_hs;

  function automatic logic [SDATA_WIDTH-1:0] interleave(input logic [SDATA_WIDTH-1:0] re,
                                                        input logic [SDATA_WIDTH-1:0] im,
                                                        input logic                   hi);
    logic [SDATA_WIDTH-1:0] w;
    int unsigned            base;
    w    = '0;
    base = hi ? Half : 32'd0;
    for (int unsigned k = 0; k < Half; k++) begin
      w[2*k*SAMPLE_WIDTH +: SAMPLE_WIDTH]     = re[(base+k)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      w[(2*k+1)*SAMPLE_WIDTH +: SAMPLE_WIDTH] = im[(base+k)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    end
    return w;
  endfunction

  // resetn gates readiness so both tready outputs drop the instant reset asserts.
  assign can_accept = resetn &&
                      ((state_q == StEmpty) || (state_q == StHi && m_axis_s2mm_tready));
  assign s_axis_real_tready = can_accept && s_axis_imag_tvalid;
  assign s_axis_imag_tready = can_accept && s_axis_real_tvalid;
  assign join_pair = can_accept && s_axis_real_tvalid && s_axis_imag_tvalid;

  assign m_axis_s2mm_tvalid = (state_q != StEmpty);
  assign m_axis_s2mm_tkeep  = {(SDATA_WIDTH/8){m_axis_s2mm_tvalid}};
  assign out_hs             = m_axis_s2mm_tvalid && m_axis_s2mm_tready;
  // Input-derived tlast is only ever attached to the HI beat of its pair.
  assign m_axis_s2mm_tlast  = m_axis_s2mm_tvalid &&
                              ((cnt_q == CntMax) || (state_q == StHi && in_last_q));

  always_comb begin
    m_axis_s2mm_tdata = '0;
    unique case (state_q)
      StLo:    m_axis_s2mm_tdata = interleave(real_q, imag_q, 1'b0);
      StHi:    m_axis_s2mm_tdata = interleave(real_q, imag_q, 1'b1);
      default: m_axis_s2mm_tdata = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    real_d    = real_q;
    imag_d    = imag_q;
    in_last_d = in_last_q;
    cnt_d     = cnt_q;
    if (join_pair) begin
      real_d    = s_axis_real_tdata;
      imag_d    = s_axis_imag_tdata;
      in_last_d = s_axis_real_tlast | s_axis_imag_tlast;
    end
    unique case (state_q)
      StEmpty: if (join_pair) state_d = StLo;
      StLo:    if (m_axis_s2mm_tready) state_d = StHi;
      StHi:    if (m_axis_s2mm_tready) state_d = join_pair ? StLo : StEmpty;
      default: state_d = StEmpty;
    endcase
    if (out_hs) cnt_d = m_axis_s2mm_tlast ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StEmpty;
      real_q    <= '0;
      imag_q    <= '0;
      in_last_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      real_q    <= real_d;
      imag_q    <= imag_d;
      in_last_q <= in_last_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef IQ_PKT_ERRFLAG_EN
  logic err_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else if (join_pair && (s_axis_real_tlast != s_axis_imag_tlast)) begin
      err_q <= 1'b1;
    end
  end

  assign err_tlast_mismatch = err_q;
`endif

endmodule

// File: tb/tb_axis_iq_packetizer.sv
// Directed self-checking bench: dut uses 256-beat packets, dut4 (same inputs) uses 4-beat packets.
module tb_axis_iq_packetizer;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         rv = 1'b0, iv = 1'b0, rl = 1'b0, il = 1'b0, mr = 1'b0;
  logic [127:0] rd = '0, id = '0;
  logic         r_rdy, i_rdy, m_valid, m_last;
  logic         r_rdy4, i_rdy4, m_valid4, m_last4;
  logic [127:0] m_data, m_data4;
  logic [15:0]  m_keep, m_keep4;
`ifdef IQ_PKT_ERRFLAG_EN
  logic         err, err4;
`endif

  int checks = 0;
  int failures = 0;

  axis_iq_packetizer #(.PACKET_BEATS(256)) dut (
    .clock(clock), .resetn(resetn),
    .s_axis_real_tvalid(rv), .s_axis_real_tready(r_rdy),
    .s_axis_real_tdata(rd), .s_axis_real_tlast(rl),
    .s_axis_imag_tvalid(iv), .s_axis_imag_tready(i_rdy),
    .s_axis_imag_tdata(id), .s_axis_imag_tlast(il),
    .m_axis_s2mm_tdata(m_data), .m_axis_s2mm_tkeep(m_keep),
    .m_axis_s2mm_tvalid(m_valid), .m_axis_s2mm_tready(mr),
`ifdef IQ_PKT_ERRFLAG_EN
    .err_tlast_mismatch(err),
`endif
    .m_axis_s2mm_tlast(m_last)
  );

  axis_iq_packetizer #(.PACKET_BEATS(4)) dut4 (
    .clock(clock), .resetn(resetn),
    .s_axis_real_tvalid(rv), .s_axis_real_tready(r_rdy4),
    .s_axis_real_tdata(rd), .s_axis_real_tlast(rl),
    .s_axis_imag_tvalid(iv), .s_axis_imag_tready(i_rdy4),
    .s_axis_imag_tdata(id), .s_axis_imag_tlast(il),
    .m_axis_s2mm_tdata(m_data4), .m_axis_s2mm_tkeep(m_keep4),
    .m_axis_s2mm_tvalid(m_valid4), .m_axis_s2mm_tready(mr),
`ifdef IQ_PKT_ERRFLAG_EN
    .err_tlast_mismatch(err4),
`endif
    .m_axis_s2mm_tlast(m_last4)
  );

  always #5 clock = ~clock;

  // Output beats are captured mid-cycle when a handshake is about to happen.
  int           cyc = 0;
  logic [127:0] q_data[$];
  logic         q_last[$];
  logic         q_last4[$];
  int           q_cyc[$];

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (resetn && m_valid && mr) begin
      q_data.push_back(m_data);
      q_last.push_back(m_last);
      q_last4.push_back(m_last4);
      q_cyc.push_back(cyc);
    end
  end

  function automatic logic [127:0] mk(input logic [15:0] base);
    logic [127:0] w;
    for (int i = 0; i < 8; i++) w[16*i +: 16] = base + 16'(i);
    return w;
  endfunction

  function automatic logic [127:0] exp_beat(input logic [15:0] rb, input logic [15:0] ib,
                                            input bit hi);
    logic [127:0] w;
    for (int k = 0; k < 4; k++) begin
      w[32*k +: 16]    = rb + (hi ? 16'd4 : 16'd0) + 16'(k);
      w[32*k+16 +: 16] = ib + (hi ? 16'd4 : 16'd0) + 16'(k);
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_q();
    q_data.delete();
    q_last.delete();
    q_last4.delete();
    q_cyc.delete();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    rv = 1'b0; iv = 1'b0; rl = 1'b0; il = 1'b0; mr = 1'b0; rd = '0; id = '0;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    clear_q();
  endtask

  // Pair p carries real samples 16p+i and imag samples 0x8000+16p+i.
  task automatic send_pairs(input int np, input logic [7:0] rf, input logic [7:0] imf);
    int   p;
    int   n;
    logic acc;
    p = 0; n = 0; mr = 1'b1;
    rd = mk(16'(16*p)); id = mk(16'(32'h8000 + 16*p)); rl = rf[p]; il = imf[p];
    rv = 1'b1; iv = 1'b1;
    while (p < np && n < 100) begin
      #1;
      acc = r_rdy;
      tick();
      n++;
      if (acc) begin
        p++;
        if (p < np) begin
          rd = mk(16'(16*p)); id = mk(16'(32'h8000 + 16*p)); rl = rf[p]; il = imf[p];
        end else begin
          rv = 1'b0; iv = 1'b0; rl = 1'b0; il = 1'b0;
        end
      end
    end
    rv = 1'b0; iv = 1'b0;
    n = 0;
    while (q_data.size() < 2*np && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    rv = 1'b1; iv = 1'b1; mr = 1'b1; rd = mk(16'h0001); id = mk(16'h8001);
    repeat (2) @(posedge clock);
    #1;
    checks++; if (r_rdy !== 1'b0) begin failures++; $display("FAIL reset_rrdy got %b exp 0", r_rdy); end
    checks++; if (i_rdy !== 1'b0) begin failures++; $display("FAIL reset_irdy got %b exp 0", i_rdy); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b exp 0", m_valid); end
    checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL reset_last got %b exp 0", m_last); end
    checks++; if (m_keep !== 16'h0) begin failures++; $display("FAIL reset_keep got %h exp 0", m_keep); end
    checks++; if (m_data !== 128'h0) begin failures++; $display("FAIL reset_data got %h exp 0", m_data); end
    do_reset();
  endtask

  task automatic test_single_pair();
    do_reset();
    rd = mk(16'h0000); id = mk(16'h8000); rv = 1'b1; iv = 1'b1; mr = 1'b1;
    #1;
    checks++; if (r_rdy !== 1'b1) begin failures++; $display("FAIL sp_rrdy got %b exp 1", r_rdy); end
    checks++; if (i_rdy !== 1'b1) begin failures++; $display("FAIL sp_irdy got %b exp 1", i_rdy); end
    tick();
    rv = 1'b0; iv = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL sp_valid0 got %b exp 1", m_valid); end
    checks++;
    if (m_data !== 128'h8003_0003_8002_0002_8001_0001_8000_0000) begin
      failures++; $display("FAIL sp_beat0 got %h exp 80030003800200028001000180000000", m_data);
    end
    checks++; if (m_keep !== 16'hFFFF) begin failures++; $display("FAIL sp_keep got %h exp ffff", m_keep); end
    checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL sp_last0 got %b exp 0", m_last); end
    tick();
    checks++;
    if (m_data !== 128'h8007_0007_8006_0006_8005_0005_8004_0004) begin
      failures++; $display("FAIL sp_beat1 got %h exp 80070007800600068005000580040004", m_data);
    end
    checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL sp_last1 got %b exp 0", m_last); end
    tick();
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL sp_idle got %b exp 0", m_valid); end
    checks++; if (m_keep !== 16'h0) begin failures++; $display("FAIL sp_keep_idle got %h exp 0", m_keep); end
  endtask

  task automatic test_full_rate();
    do_reset();
    send_pairs(4, 8'h00, 8'h00);
    checks++;
    if (q_data.size() != 8) begin failures++; $display("FAIL fr_count got %0d exp 8", q_data.size()); end
    for (int b = 0; b < 8 && b < q_data.size(); b++) begin
      checks++;
      if (q_data[b] !== exp_beat(16'(16*(b/2)), 16'(32'h8000 + 16*(b/2)), (b % 2) == 1)) begin
        failures++; $display("FAIL fr_data beat %0d got %h", b, q_data[b]);
      end
      checks++;
      if (q_last4[b] !== ((b == 3) || (b == 7))) begin
        failures++; $display("FAIL fr_last beat %0d got %b", b, q_last4[b]);
      end
      checks++;
      if (q_cyc[b] != q_cyc[0] + b) begin
        failures++; $display("FAIL fr_bubble beat %0d got cyc %0d exp %0d", b, q_cyc[b], q_cyc[0] + b);
      end
    end
  endtask

  task automatic test_early_tlast();
    do_reset();
    send_pairs(6, 8'b0000_0101, 8'b0000_0100);
    checks++;
    if (q_data.size() != 12) begin failures++; $display("FAIL et_count got %0d exp 12", q_data.size()); end
    for (int b = 0; b < 12 && b < q_data.size(); b++) begin
      checks++;
      if (q_last[b] !== ((b == 1) || (b == 5))) begin
        failures++; $display("FAIL et_last256 beat %0d got %b", b, q_last[b]);
      end
      checks++;
      if (q_last4[b] !== ((b == 1) || (b == 5) || (b == 9))) begin
        failures++; $display("FAIL et_last4 beat %0d got %b", b, q_last4[b]);
      end
    end
`ifdef IQ_PKT_ERRFLAG_EN
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL et_err got %b exp 1", err); end
`endif
  endtask

  task automatic test_backpressure();
    logic [127:0] a0, a1, b0, b1;
    a0 = exp_beat(16'h0040, 16'h9040, 1'b0); a1 = exp_beat(16'h0040, 16'h9040, 1'b1);
    b0 = exp_beat(16'h0050, 16'h9050, 1'b0); b1 = exp_beat(16'h0050, 16'h9050, 1'b1);
    do_reset();
    mr = 1'b0; rd = mk(16'h0040); id = mk(16'h9040); rv = 1'b1; iv = 1'b1;
    tick();
    rd = mk(16'h0050); id = mk(16'h9050);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL bp_valid c%0d got %b", i, m_valid); end
      checks++; if (m_data !== a0) begin failures++; $display("FAIL bp_hold c%0d got %h exp %h", i, m_data, a0); end
      checks++;
      if ({r_rdy, i_rdy} !== 2'b00) begin
        failures++; $display("FAIL bp_in_rdy c%0d got %b exp 00", i, {r_rdy, i_rdy});
      end
      tick();
    end
    mr = 1'b1;
    #1;
    checks++; if (r_rdy !== 1'b0) begin failures++; $display("FAIL bp_lo_rdy got %b exp 0", r_rdy); end
    tick();
    #1;
    checks++; if (m_data !== a1) begin failures++; $display("FAIL bp_hi got %h exp %h", m_data, a1); end
    checks++; if (r_rdy !== 1'b1) begin failures++; $display("FAIL bp_hi_rdy got %b exp 1", r_rdy); end
    tick();
    rv = 1'b0; iv = 1'b0;
    #1;
    checks++; if (m_data !== b0) begin failures++; $display("FAIL bp_next got %h exp %h", m_data, b0); end
    tick();
    tick();
    checks++;
    if (q_data.size() != 4) begin failures++; $display("FAIL bp_count got %0d exp 4", q_data.size()); end
    else begin
      checks++;
      if ({q_data[0], q_data[1], q_data[2], q_data[3]} !== {a0, a1, b0, b1}) begin
        failures++; $display("FAIL bp_order got %h %h %h %h", q_data[0], q_data[1], q_data[2], q_data[3]);
      end
    end
  endtask

  task automatic test_join_reset();
    do_reset();
    mr = 1'b1; rd = mk(16'h0100); id = mk(16'h9100); rv = 1'b1; iv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (r_rdy !== 1'b0) begin failures++; $display("FAIL jr_rrdy c%0d got %b exp 0", i, r_rdy); end
      checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL jr_valid c%0d got %b exp 0", i, m_valid); end
      tick();
    end
    iv = 1'b1;
    tick();
    tick();
    tick();
    #3;
    resetn = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL jr_rst_valid got %b exp 0", m_valid); end
    checks++; if (m_data !== 128'h0) begin failures++; $display("FAIL jr_rst_data got %h exp 0", m_data); end
    checks++; if (m_keep !== 16'h0) begin failures++; $display("FAIL jr_rst_keep got %h exp 0", m_keep); end
    checks++; if (m_last4 !== 1'b0) begin failures++; $display("FAIL jr_rst_last got %b exp 0", m_last4); end
    checks++;
    if ({r_rdy, i_rdy} !== 2'b00) begin failures++; $display("FAIL jr_rst_rdy got %b exp 00", {r_rdy, i_rdy}); end
    rv = 1'b0; iv = 1'b0;
    tick();
    resetn = 1'b1;
    clear_q();
    send_pairs(2, 8'h00, 8'h00);
    checks++;
    if (q_last4.size() != 4) begin failures++; $display("FAIL jr_count got %0d exp 4", q_last4.size()); end
    else begin
      checks++;
      if ({q_last4[0], q_last4[1], q_last4[2], q_last4[3]} !== 4'b0001) begin
        failures++;
        $display("FAIL jr_cnt_restart got %b%b%b%b exp 0001", q_last4[0], q_last4[1], q_last4[2], q_last4[3]);
      end
    end
  endtask

`ifdef IQ_PKT_ERRFLAG_EN
  task automatic test_err_flag();
    do_reset();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL ef_init got %b exp 0", err); end
    mr = 1'b1; rd = mk(16'h0200); id = mk(16'h9200); rl = 1'b1; il = 1'b0; rv = 1'b1; iv = 1'b1;
    #1;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL ef_pre got %b exp 0", err); end
    tick();
    rv = 1'b0; iv = 1'b0; rl = 1'b0;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL ef_set got %b exp 1", err); end
    repeat (3) tick();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL ef_sticky got %b exp 1", err); end
    resetn = 1'b0;
    #1;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL ef_clear got %b exp 0", err); end
    tick();
    resetn = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_single_pair();
    test_full_rate();
    test_early_tlast();
    test_backpressure();
    test_join_reset();
`ifdef IQ_PKT_ERRFLAG_EN
    test_err_flag();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
